// File: rtl/sqrt_pkg.sv
// Shared constants, state encoding and helpers for the BCD square-root sequencer.
package sqrt_pkg;

  localparam int DIGITS      = 6;
  localparam int FRAC_DIGITS = 3;
  localparam int ROOT_BITS   = 20;
  localparam int ACC_W       = 40;
  localparam int BCD_W       = 4 * DIGITS;
  localparam int REM_W       = ROOT_BITS + 2;
  localparam int CNT_W       = 5;

  typedef logic [2:0] state_t;
  localparam state_t IDLE  = 3'd0;
  localparam state_t CONV  = 3'd1;
  localparam state_t SCALE = 3'd2;
  localparam state_t ROOT  = 3'd3;
  localparam state_t B2D   = 3'd4;
  localparam state_t DONE  = 3'd5;

  localparam logic [CNT_W-1:0] CONV_LAST  = CNT_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] SCALE_LAST = CNT_W'(2 * FRAC_DIGITS - 1);
  localparam logic [CNT_W-1:0] ROOT_LAST  = CNT_W'(ROOT_BITS - 1);

  function automatic logic bcd_valid(input logic [BCD_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

  function automatic logic [3:0] dd_adjust(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/sqrt_sequencer_if.sv
// Start/busy/done handshake and operand/result bus between digit entry and display.
interface sqrt_sequencer_if;
  import sqrt_pkg::*;

  logic             start;
  logic [BCD_W-1:0] operand_bcd;
  logic             busy;
  logic             done;
  logic             error;
  logic [BCD_W-1:0] result_bcd;

  modport master (output start, output operand_bcd,
                  input busy, input done, input error, input result_bcd);
  modport slave  (input start, input operand_bcd,
                  output busy, output done, output error, output result_bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double dabble: one shift-add-3 step per asserted step cycle.
// bcd_o is the digit vector as it will be after the current step.
module bin_to_bcd_seq
  import sqrt_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic [ROOT_BITS-1:0] bin_i,
  output logic [BCD_W-1:0]     bcd_o
);

  logic [ROOT_BITS-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]     bcd_q, bcd_d;
  logic [BCD_W-2:0]     bcd_adj;

  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS - 1; i++) begin
      bcd_adj[4*i +: 4] = dd_adjust(bcd_q[4*i +: 4]);
    end
    // The top digit's carry-out would be shifted away, so only its low 3 bits matter.
    bcd_adj[BCD_W-2 -: 3] = 3'(dd_adjust(bcd_q[BCD_W-1 -: 4]));
    bcd_o = {bcd_adj, bin_q[ROOT_BITS-1]};

    bin_d = bin_q;
    bcd_d = bcd_q;
    if (load) begin
      bin_d = bin_i;
      bcd_d = '0;
    end else if (step) begin
      bin_d = {bin_q[ROOT_BITS-2:0], 1'b0};
      bcd_d = bcd_o;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
    end
  end

endmodule

// File: rtl/sqrt_sequencer.sv
// BCD entry -> floor(sqrt(N * 10^6)) as XXX.YYY BCD, through one shared
// accumulator: BCD-to-binary, scale, restoring root, then double dabble.
module sqrt_sequencer
  import sqrt_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  sqrt_sequencer_if.slave  bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BCD_W-1:0]     op_q, op_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [REM_W-1:0]     rem_q, rem_d;
  logic [ROOT_BITS-1:0] root_q, root_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic [BCD_W-1:0]     result_q, result_d;

  logic [REM_W+1:0]     rem_shift, trial;
  logic [REM_W-1:0]     rem_sub;
  logic                 take;
  logic [ROOT_BITS-1:0] root_next;
  logic                 b2d_load, b2d_step;
  logic [BCD_W-1:0]     b2d_bcd;

  // Restoring root step: the shifted partial remainder needs two bits more
  // than the register so the comparison never wraps.
  always_comb begin
    rem_shift = {rem_q, acc_q[ACC_W-1 -: 2]};
    trial     = {2'b00, root_q, 2'b01};
    take      = (rem_shift >= trial);
    rem_sub   = rem_shift[REM_W-1:0] - trial[REM_W-1:0];
    root_next = {root_q[ROOT_BITS-2:0], take};
  end

  bin_to_bcd_seq u_b2d (
    .clock (clock),
    .reset (reset),
    .load  (b2d_load),
    .step  (b2d_step),
    .bin_i (root_next),
    .bcd_o (b2d_bcd)
  );

  always_comb begin
    // NOTE: every signal gets a hold/idle default before the case so no path leaves it unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    root_d   = root_q;
    done_d   = 1'b0;
    error_d  = error_q;
    result_d = result_q;
    b2d_load = 1'b0;
    b2d_step = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d   = bus.operand_bcd;
          acc_d  = '0;
          rem_d  = '0;
          root_d = '0;
          cnt_d  = '0;
          if (bcd_valid(bus.operand_bcd)) begin
            state_d = CONV;
          end else begin
            state_d  = DONE;
            done_d   = 1'b1;
            error_d  = 1'b1;
            result_d = '0;
          end
        end
      end
      CONV: begin
        acc_d = acc_q * ACC_W'(10) + ACC_W'(op_q[BCD_W-1 -: 4]);
        op_d  = op_q << 4;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CONV_LAST) begin
          state_d = SCALE;
          cnt_d   = '0;
        end
      end
      SCALE: begin
        acc_d = acc_q * ACC_W'(10);
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == SCALE_LAST) begin
          state_d = ROOT;
          cnt_d   = '0;
        end
      end
      ROOT: begin
        rem_d  = take ? rem_sub : rem_shift[REM_W-1:0];
        root_d = root_next;
        acc_d  = acc_q << 2;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == ROOT_LAST) begin
          state_d  = B2D;
          cnt_d    = '0;
          b2d_load = 1'b1;
        end
      end
      B2D: begin
        b2d_step = 1'b1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == ROOT_LAST) begin
          state_d  = DONE;
          cnt_d    = '0;
          done_d   = 1'b1;
          error_d  = 1'b0;
          result_d = b2d_bcd;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CONV) || (state_d == SCALE) ||
             (state_d == ROOT) || (state_d == B2D);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      root_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      root_q   <= root_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.result_bcd = result_q;

endmodule
